// File: rtl/row_config_loader.sv
// row_config_loader: collects a row's configuration bitstream as 32-bit words,
// verifies an XOR checksum word, and only then commits the whole prog vector
// in one edge so the row never sees a partial or corrupt image.
module row_config_loader #(
    parameter int PROG_W = 552,
    parameter int WORD_W = 32
) (
    input  logic              clb_clk,
    input  logic              clb_rst_n,
    input  logic              cfg_start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [PROG_W-1:0] prog,
    output logic              prog_valid,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              busy
);

    localparam int NUM_WORDS = (PROG_W + WORD_W - 1) / WORD_W;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);
    localparam int SHADOW_W  = NUM_WORDS * WORD_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Running checksum: plain XOR of every data word, including the unused
    // upper bits of the last word.
    function automatic logic [WORD_W-1:0] csum_update(
        input logic [WORD_W-1:0] acc,
        input logic [WORD_W-1:0] word
    );
        return acc ^ word;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    counter_r;
    logic [WORD_W-1:0]   acc_r;
    logic [SHADOW_W-1:0] shadow_r;
    logic [PROG_W-1:0]   prog_r;
    logic                prog_valid_r;
    logic                cfg_done_r;
    logic                cfg_err_r;

    logic                beat_s;
    logic                clear_s;
    logic                load_beat_s;
    logic                commit_s;
    logic                fail_s;

    assign cfg_ready  = (state_r != IDLE);
    assign busy       = (state_r != IDLE);
    assign beat_s     = cfg_valid & cfg_ready;
    assign prog       = prog_r;
    assign prog_valid = prog_valid_r;
    assign cfg_done   = cfg_done_r;
    assign cfg_err    = cfg_err_r;

    // State register.
    always_ff @(posedge clb_clk or negedge clb_rst_n) begin
        if (!clb_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control decode; cfg_start always takes priority
    // over a beat in the same cycle.
    always_comb begin
        state_s     = state_r;
        clear_s     = 1'b0;
        load_beat_s = 1'b0;
        commit_s    = 1'b0;
        fail_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (cfg_start) begin
                    clear_s = 1'b1;
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (cfg_start) begin
                    clear_s = 1'b1;
                    state_s = LOAD;
                end else if (beat_s) begin
                    load_beat_s = 1'b1;
                    if (counter_r == LAST_IDX) begin
                        state_s = CHECK;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            CHECK: begin
                if (cfg_start) begin
                    clear_s = 1'b1;
                    state_s = LOAD;
                end else if (beat_s) begin
                    if (cfg_data == acc_r) begin
                        commit_s = 1'b1;
                    end else begin
                        fail_s = 1'b1;
                    end
                    state_s = IDLE;
                end else begin
                    state_s = CHECK;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Word counter, checksum accumulator and shadow assembly.
    always_ff @(posedge clb_clk or negedge clb_rst_n) begin
        if (!clb_rst_n) begin
            counter_r <= '0;
            acc_r     <= '0;
            shadow_r  <= '0;
        end else if (clear_s) begin
            counter_r <= '0;
            acc_r     <= '0;
        end else if (load_beat_s) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (counter_r == CNT_W'(k)) begin
                    shadow_r[k*WORD_W +: WORD_W] <= cfg_data;
                end
            end
            acc_r     <= csum_update(acc_r, cfg_data);
            counter_r <= counter_r + CNT_W'(1);
        end
    end

    // Committed image and status flags; prog moves only on a good checksum.
    always_ff @(posedge clb_clk or negedge clb_rst_n) begin
        if (!clb_rst_n) begin
            prog_r       <= '0;
            prog_valid_r <= 1'b0;
            cfg_done_r   <= 1'b0;
            cfg_err_r    <= 1'b0;
        end else begin
            cfg_done_r <= commit_s;
            if (commit_s) begin
                prog_r       <= shadow_r[PROG_W-1:0];
                prog_valid_r <= 1'b1;
            end
            if (clear_s) begin
                cfg_err_r <= 1'b0;
            end else if (fail_s) begin
                cfg_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_row_config_loader.sv
// Self-checking bench for row_config_loader: directed scenarios plus random
// loads, compared every cycle against a queue-based reference model.
module tb_row_config_loader;

    localparam int PROG_W    = 552;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 18;

    logic              clb_clk;
    logic              clb_rst_n;
    logic              cfg_start;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [PROG_W-1:0] prog;
    logic              prog_valid;
    logic              cfg_done;
    logic              cfg_err;
    logic              busy;

    row_config_loader #(.PROG_W(PROG_W), .WORD_W(WORD_W)) dut (
        .clb_clk    (clb_clk),
        .clb_rst_n  (clb_rst_n),
        .cfg_start  (cfg_start),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .prog       (prog),
        .prog_valid (prog_valid),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .busy       (busy)
    );

    initial clb_clk = 1'b0;
    always #5 clb_clk = ~clb_clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [PROG_W-1:0] m_prog;
    logic              m_valid;
    logic              m_done;
    logic              m_err;
    logic              m_active;
    logic [WORD_W-1:0] m_q[$];

    logic [WORD_W-1:0] wbuf [NUM_WORDS];
    logic [PROG_W-1:0] ones_img;

    task automatic check_eq(input string tag, input logic [PROG_W-1:0] got,
                            input logic [PROG_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string phase);
        check_eq({phase, ".prog"},       prog,       m_prog);
        check_eq({phase, ".prog_valid"}, prog_valid, m_valid);
        check_eq({phase, ".cfg_done"},   cfg_done,   m_done);
        check_eq({phase, ".cfg_err"},    cfg_err,    m_err);
        check_eq({phase, ".cfg_ready"},  cfg_ready,  m_active);
        check_eq({phase, ".busy"},       busy,       m_active);
    endtask

    task automatic model_reset();
        m_prog   = '0;
        m_valid  = 1'b0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_active = 1'b0;
        m_q.delete();
    endtask

    // One clock: drive inputs, advance, update model, compare.
    task automatic step(input logic s, input logic v, input logic [WORD_W-1:0] d);
        logic [WORD_W-1:0] x;
        logic [NUM_WORDS*WORD_W-1:0] img;
        cfg_start = s;
        cfg_valid = v;
        cfg_data  = d;
        @(posedge clb_clk);
        m_done = 1'b0;
        if (s) begin
            m_active = 1'b1;
            m_err    = 1'b0;
            m_q.delete();
        end else if (m_active && v) begin
            if (m_q.size() < NUM_WORDS) begin
                m_q.push_back(d);
            end else begin
                x = '0;
                foreach (m_q[i]) x = x ^ m_q[i];
                if (d == x) begin
                    img = '0;
                    for (int k = 0; k < NUM_WORDS; k++) img[k*WORD_W +: WORD_W] = m_q[k];
                    m_prog  = img[PROG_W-1:0];
                    m_valid = 1'b1;
                    m_done  = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_active = 1'b0;
                m_q.delete();
            end
        end
        #1;
        check_all("cyc");
    endtask

    // gap_mode 0: none, 1: one idle cycle before every word, 2: random gaps
    task automatic send_word(input logic [WORD_W-1:0] d, input int gap_mode);
        if (gap_mode == 1) begin
            step(1'b0, 1'b0, $urandom());
        end else if (gap_mode == 2) begin
            while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, $urandom());
        end
        step(1'b0, 1'b1, d);
    endtask

    function automatic logic [WORD_W-1:0] xor_wbuf();
        logic [WORD_W-1:0] x;
        x = '0;
        for (int k = 0; k < NUM_WORDS; k++) x = x ^ wbuf[k];
        return x;
    endfunction

    task automatic do_load(input logic [WORD_W-1:0] csum, input int gap_mode);
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < NUM_WORDS; k++) send_word(wbuf[k], gap_mode);
        send_word(csum, gap_mode);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
    endtask

    task automatic fill_const(input logic [WORD_W-1:0] w);
        for (int k = 0; k < NUM_WORDS; k++) wbuf[k] = w;
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < NUM_WORDS; k++) wbuf[k] = 32'h0101_0101 * (k + 1);
    endtask

    task automatic async_reset();
        clb_rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #2;
        clb_rst_n = 1'b1;
    endtask

    initial begin
        logic [PROG_W-1:0] ramp_img;
        ones_img  = '1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        clb_rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset_imm");
        repeat (2) @(posedge clb_clk);
        #1;
        check_all("reset_hold");
        clb_rst_n = 1'b1;

        // Valid words in IDLE must be ignored
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom());

        // Good load: all ones, checksum 0
        fill_const(32'hFFFF_FFFF);
        do_load(32'h0, 0);
        check_eq("all_ones_img", prog, ones_img);

        // Bad checksum: prog stays all ones, error sticky
        fill_const(32'h0);
        do_load(32'h1, 0);
        check_eq("bad_keeps_img", prog, ones_img);
        check_eq("bad_err", cfg_err, 1'b1);
        step(1'b0, 1'b0, '0);

        // Throttled ramp pattern (start clears the error)
        fill_ramp();
        do_load(xor_wbuf(), 1);
        ramp_img = prog;
        check_eq("ramp_top_byte", ramp_img[551:544], 8'h12);
        check_eq("ramp_word0", ramp_img[31:0], 32'h0101_0101);

        // Same pattern gap-free after a different image must give identical prog
        fill_const(32'hFFFF_FFFF);
        do_load(32'h0, 0);
        fill_ramp();
        do_load(xor_wbuf(), 0);
        check_eq("ramp_gapfree_same", prog, ramp_img);

        // Restart after 5 words of AA, prog unchanged until commit
        fill_const(32'hFFFF_FFFF);
        do_load(32'h0, 0);
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < 5; k++) send_word(32'hAAAA_AAAA, 0);
        fill_ramp();
        do_load(xor_wbuf(), 0);
        check_eq("restart_img", prog, ramp_img);

        // Start colliding with the checksum beat: no commit, no error
        fill_const(32'h0);
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < NUM_WORDS; k++) send_word(wbuf[k], 0);
        step(1'b1, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h5);
        check_eq("collide_keeps_img", prog, ramp_img);

        // Reset during word 10 after a good commit, then recover
        fill_ramp();
        do_load(xor_wbuf(), 0);
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < 10; k++) send_word(wbuf[k], 0);
        async_reset();
        check_eq("midload_rst_prog", prog, '0);
        do_load(xor_wbuf(), 0);
        check_eq("recover_img", prog, ramp_img);

        // Randomized loads: random data, gaps, bad checksums, aborts
        for (int it = 0; it < 30; it++) begin
            int kind;
            kind = $urandom_range(0, 3);
            for (int k = 0; k < NUM_WORDS; k++) wbuf[k] = $urandom();
            if (kind == 0) begin
                do_load(xor_wbuf(), 2);
            end else if (kind == 1) begin
                do_load(xor_wbuf() ^ (32'h1 << $urandom_range(0, 31)), 2);
            end else if (kind == 2) begin
                step(1'b1, 1'b0, '0);
                for (int k = 0; k < int'($urandom_range(1, 17)); k++) send_word($urandom(), 2);
                do_load(xor_wbuf(), 2);
            end else begin
                step(1'b0, 1'b1, $urandom());
                do_load(xor_wbuf(), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
